// File: rtl/bmp_egress_buffer.sv
// bmp_egress_buffer: two-channel egress buffer for the accelerator master port.
// Words tagged 01/10 go to a per-channel first-word-fall-through FIFO. A per-channel
// frame FSM counts words per image and reports the frame length once drained.
// Optional feature: define EGRESS_CHECKSUM_EN for per-frame mod-2^DATA_WIDTH checksums;
// when undefined the checksum ports are tied to zero.
module bmp_egress_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_valid,
    input  logic                  in_cmplt,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [1:0]            frame_done,
    output logic [CNT_WIDTH-1:0]  frame_cnt0,
    output logic [CNT_WIDTH-1:0]  frame_cnt1,
    output logic [DATA_WIDTH-1:0] checksum0,
    output logic [DATA_WIDTH-1:0] checksum1,
    output logic                  err_illegal
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    // RUN collects a frame, DRAIN waits for the FIFO to empty, DONE reports it.
    typedef enum logic [1:0] { ST_RUN, ST_DRAIN, ST_DONE } state_t;

    logic [DATA_WIDTH-1:0] mem_q       [2][FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q    [2];
    logic [PW-1:0]         rd_ptr_q    [2];
    logic [CW-1:0]         count_q     [2];
    state_t                state_q     [2];
    state_t                state_d     [2];
    logic [CNT_WIDTH-1:0]  run_q       [2];  // words of the frame being closed
    logic [CNT_WIDTH-1:0]  nxt_run_q   [2];  // words arriving for the next frame while draining
    logic [CNT_WIDTH-1:0]  frame_cnt_q [2];
    logic                  last_ch_q;
    logic                  err_q;

    logic [1:0] push, pop, not_empty, out_ready, cmplt_hit;
    logic       cmplt_ch, illegal;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign out_ready    = {out1_ready, out0_ready};
    assign not_empty[0] = (count_q[0] != '0);
    assign not_empty[1] = (count_q[1] != '0);
    // Registered counts only: a same-cycle pop never opens the input.
    assign in_ready     = (count_q[0] != FULL) && (count_q[1] != FULL);
    assign push[0]      = in_ready && (in_valid == 2'b01);
    assign push[1]      = in_ready && (in_valid == 2'b10);
    assign illegal      = in_ready && (in_valid == 2'b11);
    assign pop          = not_empty & out_ready;
    // End-of-image follows a same-cycle word, otherwise the most recent channel.
    assign cmplt_ch     = push[1] | (~push[0] & last_ch_q);
    assign cmplt_hit    = in_cmplt ? (cmplt_ch ? 2'b10 : 2'b01) : 2'b00;

    // FIFO pointers and occupancy; pointers wrap modulo the depth.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PW'(1);
                if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + PW'(1);
                if (push[c] && !pop[c])      count_q[c] <= count_q[c] + CW'(1);
                else if (pop[c] && !push[c]) count_q[c] <= count_q[c] - CW'(1);
            end
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the occupancy count alone decides what is valid.
        for (int c = 0; c < 2; c++) begin
            if (push[c]) mem_q[c][wr_ptr_q[c]] <= in_data;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= ST_RUN;
            state_q[1] <= ST_RUN;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // Frame FSM next state; an end-of-image outside RUN is merged into the pending one.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            // NOTE: default first so every path assigns state_d and no latch is inferred.
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_RUN:   if (cmplt_hit[c]) state_d[c] = ST_DRAIN;
                ST_DRAIN: if (!not_empty[c] && !push[c]) state_d[c] = ST_DONE;
                ST_DONE:  state_d[c] = ST_RUN;
                default:  state_d[c] = ST_RUN;
            endcase
        end
    end

    // Word counters, reported lengths, last channel and the illegal-code pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                run_q[c]       <= '0;
                nxt_run_q[c]   <= '0;
                frame_cnt_q[c] <= '0;
            end
            last_ch_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                case (state_q[c])
                    ST_RUN:   if (push[c]) run_q[c] <= sat_inc(run_q[c]);
                    ST_DRAIN: if (push[c]) nxt_run_q[c] <= sat_inc(nxt_run_q[c]);
                    ST_DONE: begin
                        frame_cnt_q[c] <= run_q[c];
                        run_q[c]       <= push[c] ? sat_inc(nxt_run_q[c]) : nxt_run_q[c];
                        nxt_run_q[c]   <= '0;
                    end
                    default: ;
                endcase
            end
            if (push[0])      last_ch_q <= 1'b0;
            else if (push[1]) last_ch_q <= 1'b1;
            err_q <= illegal;
        end
    end

`ifdef EGRESS_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q      [2];
    logic [DATA_WIDTH-1:0] nxt_sum_q  [2];
    logic [DATA_WIDTH-1:0] checksum_q [2];

    // Per-frame checksum, split between the closing and the next frame like the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                sum_q[c]      <= '0;
                nxt_sum_q[c]  <= '0;
                checksum_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                case (state_q[c])
                    ST_RUN:   if (push[c]) sum_q[c] <= sum_q[c] + in_data;
                    ST_DRAIN: if (push[c]) nxt_sum_q[c] <= nxt_sum_q[c] + in_data;
                    ST_DONE: begin
                        checksum_q[c] <= sum_q[c];
                        sum_q[c]      <= push[c] ? nxt_sum_q[c] + in_data : nxt_sum_q[c];
                        nxt_sum_q[c]  <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign checksum0 = checksum_q[0];
    assign checksum1 = checksum_q[1];
`else
    assign checksum0 = '0;
    assign checksum1 = '0;
`endif

    // Heads are gated so outputs read zero while a FIFO is empty.
    assign out0_valid  = not_empty[0];
    assign out1_valid  = not_empty[1];
    assign out0_data   = not_empty[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    assign out1_data   = not_empty[1] ? mem_q[1][rd_ptr_q[1]] : '0;
    assign frame_done  = {state_q[1] == ST_DONE, state_q[0] == ST_DONE};
    assign frame_cnt0  = frame_cnt_q[0];
    assign frame_cnt1  = frame_cnt_q[1];
    assign err_illegal = err_q;

endmodule
